// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, blanking and strobes.
// Latency: syncs and video_on are registered from next-state counters; en=0 freezes state and drops strobes.
module vga_timing_gen #(
    parameter int HD      = 640,
    parameter int HFP     = 16,
    parameter int HSW     = 96,
    parameter int HBP     = 48,
    parameter int VD      = 480,
    parameter int VFP     = 10,
    parameter int VSW     = 2,
    parameter int VBP     = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CLK_DIV = 2,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic          pixel_tick,
    output logic          line_end,
    output logic          frame_start
);

    localparam int HTOT = HD + HFP + HSW + HBP;
    localparam int VTOT = VD + VFP + VSW + VBP;
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(HTOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(VTOT - 1);
    localparam logic [CW-1:0] H_DISP   = CW'(HD);
    localparam logic [CW-1:0] V_DISP   = CW'(VD);
    localparam logic [CW-1:0] HS_FIRST = CW'(HD + HFP);
    localparam logic [CW-1:0] HS_LAST  = CW'(HD + HFP + HSW - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(VD + VFP);
    localparam logic [CW-1:0] VS_LAST  = CW'(VD + VFP + VSW - 1);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          video_on_q, video_on_d;
    logic          tick;
    logic          at_h_last;
    logic          at_v_last;

    // Strobes are gated by reset so they read low while it is held, even at CLK_DIV=1.
    assign tick      = reset & en & (div_q == DIV_LAST);
    assign at_h_last = (x_q == H_LAST);
    assign at_v_last = (y_q == V_LAST);

    always_comb begin
        div_d      = div_q;
        x_d        = x_q;
        y_d        = y_q;
        h_sync_d   = h_sync_q;
        v_sync_d   = v_sync_q;
        video_on_d = video_on_q;

        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        if (tick) begin
            x_d = at_h_last ? '0 : x_q + 1'b1;
            if (at_h_last) begin
                y_d = at_v_last ? '0 : y_q + 1'b1;
            end
        end

        // Decoding the next counter values keeps these flops aligned with pixel_x/pixel_y.
        h_sync_d   = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
        v_sync_d   = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
        video_on_d = (x_d < H_DISP) && (y_d < V_DISP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            h_sync_q   <= ~HS_POL;
            v_sync_q   <= ~VS_POL;
            video_on_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            h_sync_q   <= h_sync_d;
            v_sync_q   <= v_sync_d;
            video_on_q <= video_on_d;
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign video_on    = video_on_q;
    assign pixel_tick  = tick;
    assign line_end    = tick & at_h_last;
    assign frame_start = tick & at_h_last & at_v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (horizontal, enable, reset) and a tiny override geometry for full frames.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       d_rst_n, d_en;
    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_von, d_tick, d_le, d_fs;

    // Small override instance
    logic       s_rst_n, s_en;
    logic [3:0] s_x, s_y;
    logic       s_hs, s_vs, s_von, s_tick, s_le, s_fs;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen u_dflt (
        .clk(clk), .reset(d_rst_n), .en(d_en),
        .pixel_x(d_x), .pixel_y(d_y), .h_sync(d_hs), .v_sync(d_vs), .video_on(d_von),
        .pixel_tick(d_tick), .line_end(d_le), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .HD(4), .HFP(1), .HSW(2), .HBP(1), .VD(3), .VFP(1), .VSW(1), .VBP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(4)
    ) u_small (
        .clk(clk), .reset(s_rst_n), .en(s_en),
        .pixel_x(s_x), .pixel_y(s_y), .h_sync(s_hs), .v_sync(s_vs), .video_on(s_von),
        .pixel_tick(s_tick), .line_end(s_le), .frame_start(s_fs)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, les, fss, le_bad, dbl, hs_low, vs_low;
        int hs_fall_x, hs_rise_x, von_fall_x, von_rise_x;
        logic prev_hs, prev_von, prev_tick;
        int k, line_ticks, hold_bad;
        logic seen_le;
        int hs_hi, vs_hi, hs_bad, vs_bad, von_bad, fs_pos_bad, fs_next_bad;
        logic after_fs;

        d_rst_n = 1'b0; d_en = 1'b0;
        s_rst_n = 1'b0; s_en = 1'b0;

        // Reset held with en toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d_en = (i % 2 == 0);
            s_en = 1'b1;
            #1;
            check("rst_d_strobes", {d_tick, d_le, d_fs}, 0);
            check("rst_s_strobes", {s_tick, s_le, s_fs}, 0);
        end
        check("rst_d_x", d_x, 0);
        check("rst_d_y", d_y, 0);
        check("rst_d_hs", d_hs, 1);
        check("rst_d_vs", d_vs, 1);
        check("rst_d_von", d_von, 0);
        check("rst_s_hs", s_hs, 0);
        check("rst_s_vs", s_vs, 0);
        check("rst_s_von", s_von, 0);

        // Release default instance
        @(negedge clk);
        d_rst_n = 1'b1; d_en = 1'b1;
        #1;
        check("rel_tick0", d_tick, 0);
        @(negedge clk);
        check("rel_von", d_von, 1);
        check("rel_x0", d_x, 0);
        check("rel_tick1", d_tick, 1);
        @(negedge clk);
        check("rel_x1", d_x, 1);
        check("rel_tick2", d_tick, 0);

        // Two full lines of horizontal behaviour
        ticks = 0; les = 0; fss = 0; le_bad = 0; dbl = 0; hs_low = 0; vs_low = 0;
        hs_fall_x = -1; hs_rise_x = -1; von_fall_x = -1; von_rise_x = -1;
        prev_hs = d_hs; prev_von = d_von; prev_tick = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            if (d_tick) ticks++;
            if (d_tick && prev_tick) dbl++;
            if (d_le) begin
                les++;
                if (d_x != 10'd799) le_bad++;
            end
            if (d_fs) fss++;
            if (!d_hs) hs_low++;
            if (!d_vs) vs_low++;
            if (prev_hs && !d_hs && hs_fall_x < 0) hs_fall_x = d_x;
            if (!prev_hs && d_hs && hs_rise_x < 0) hs_rise_x = d_x;
            if (prev_von && !d_von && von_fall_x < 0) von_fall_x = d_x;
            if (!prev_von && d_von && von_rise_x < 0) von_rise_x = d_x;
            prev_hs = d_hs; prev_von = d_von; prev_tick = d_tick;
            @(negedge clk);
        end
        check("line_ticks", ticks, 1600);
        check("line_no_back2back", dbl, 0);
        check("line_end_count", les, 2);
        check("line_end_at_799", le_bad, 0);
        check("line_no_frame", fss, 0);
        check("hs_low_clks", hs_low, 384);
        check("hs_fall_x", hs_fall_x, 656);
        check("hs_rise_x", hs_rise_x, 752);
        check("von_fall_x", von_fall_x, 640);
        check("von_rise_x", von_rise_x, 0);
        check("vs_low_in_lines", vs_low, 0);
        check("line_pos_x", d_x, 1);
        check("line_pos_y", d_y, 2);

        // Enable pause at pixel_x 300 on line 2
        line_ticks = 1;
        k = 0;
        while (d_x != 10'd300 && k < 2000) begin
            if (d_tick) line_ticks++;
            @(negedge clk);
            k++;
        end
        check("reach_x300", int'(k < 2000), 1);
        check("x300_tick", d_tick, 0);
        d_en = 1'b0;
        hold_bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (d_x != 10'd300 || d_y != 10'd2 || {d_tick, d_le, d_fs} != 3'b000) hold_bad++;
        end
        check("pause_hold", hold_bad, 0);
        d_en = 1'b1;
        #1;
        check("resume_tick0", d_tick, 0);
        @(negedge clk);
        check("resume_x300", d_x, 300);
        check("resume_tick1", d_tick, 1);
        line_ticks++;
        @(negedge clk);
        check("resume_x301", d_x, 301);
        seen_le = 1'b0;
        k = 0;
        while (!seen_le && k < 2000) begin
            if (d_tick) line_ticks++;
            if (d_le) seen_le = 1'b1;
            @(negedge clk);
            k++;
        end
        check("paused_line_ticks", line_ticks, 800);
        check("paused_line_wrap_x", d_x, 0);
        check("paused_line_wrap_y", d_y, 3);

        // Mid-frame reset while inside horizontal sync
        k = 0;
        while (d_x != 10'd700 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reach_x700", int'(k < 2000), 1);
        check("x700_hs", d_hs, 0);
        check("x700_von", d_von, 0);
        d_rst_n = 1'b0;
        #1;
        check("mid_rst_x", d_x, 0);
        check("mid_rst_y", d_y, 0);
        check("mid_rst_hs", d_hs, 1);
        check("mid_rst_vs", d_vs, 1);
        check("mid_rst_von", d_von, 0);
        check("mid_rst_strobes", {d_tick, d_le, d_fs}, 0);
        repeat (3) @(negedge clk);
        d_rst_n = 1'b1;
        #1;
        check("mid_rel_tick0", d_tick, 0);
        @(negedge clk);
        check("mid_rel_x0", d_x, 0);
        check("mid_rel_von", d_von, 1);
        check("mid_rel_tick1", d_tick, 1);
        @(negedge clk);
        check("mid_rel_x1", d_x, 1);

        // Small geometry: two full frames at one pixel per clk
        @(negedge clk);
        s_rst_n = 1'b1;
        #1;
        check("s_rel_tick", s_tick, 1);
        @(negedge clk);
        check("s_first_x", s_x, 1);
        check("s_first_von", s_von, 1);
        ticks = 0; les = 0; fss = 0; hs_hi = 0; vs_hi = 0;
        hs_bad = 0; vs_bad = 0; von_bad = 0; fs_pos_bad = 0; fs_next_bad = 0;
        after_fs = 1'b0;
        for (int i = 0; i < 96; i++) begin
            if (after_fs && (s_x != 4'd0 || s_y != 4'd0)) fs_next_bad++;
            after_fs = s_fs;
            if (s_tick) ticks++;
            if (s_le) les++;
            if (s_fs) begin
                fss++;
                if (s_x != 4'd7 || s_y != 4'd5) fs_pos_bad++;
            end
            if (s_hs) hs_hi++;
            if (s_vs) vs_hi++;
            if (s_hs != (s_x == 4'd5 || s_x == 4'd6)) hs_bad++;
            if (s_vs != (s_y == 4'd4)) vs_bad++;
            if (s_von != (s_x < 4'd4 && s_y < 4'd3)) von_bad++;
            @(negedge clk);
        end
        check("s_ticks", ticks, 96);
        check("s_line_ends", les, 12);
        check("s_frame_starts", fss, 2);
        check("s_frame_start_pos", fs_pos_bad, 0);
        check("s_frame_wrap", fs_next_bad, 0);
        check("s_hs_high_clks", hs_hi, 24);
        check("s_hs_window", hs_bad, 0);
        check("s_vs_high_clks", vs_hi, 16);
        check("s_vs_window", vs_bad, 0);
        check("s_von_window", von_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter HD, default 640, horizontal display pixels.
REQ-002 SHALL have parameter HFP, default 16, horizontal front porch (after display).
REQ-003 SHALL have parameter HSW, default 96, horizontal sync width.
REQ-004 SHALL have parameter HBP, default 48, horizontal back porch.
REQ-005 SHALL have parameter VD, default 480, vertical display lines.
REQ-006 SHALL have parameter VFP, default 10, vertical front porch lines.
REQ-007 SHALL have parameter VSW, default 2, vertical sync width lines.
REQ-008 SHALL have parameter VBP, default 33, vertical back porch lines.
REQ-009 SHALL have parameter HS_POL, default 0, h_sync active level (0 = active-low).
REQ-010 SHALL have parameter VS_POL, default 0, v_sync active level.
REQ-011 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel (>=1).
REQ-012 SHALL have parameter CW, default 10, counter width; must hold HTOT-1 and VTOT-1.
REQ-013 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-low reset; en in 1 timing run enable; pixel_x out CW horizontal count; pixel_y out CW vertical count; h_sync out 1; v_sync out 1; video_on out 1 display-region flag; pixel_tick out 1 pixel strobe; line_end out 1 last-pixel-of-line strobe; frame_start out 1 frame-wrap strobe.

Function
REQ-014 SHALL define HTOT = HD+HFP+HSW+HBP and VTOT = VD+VFP+VSW+VBP.
REQ-015 SHALL contain a divider counter 0..CLK_DIV-1 advancing each clk while en=1; pixel_tick=1 for exactly the clk in which divider = CLK_DIV-1 and en=1; CLK_DIV=1 gives pixel_tick = en.
REQ-016 SHALL, while en=0, hold divider, pixel_x, pixel_y, h_sync, v_sync constant and force pixel_tick, line_end, frame_start to 0.
REQ-017 SHALL advance pixel_x on each pixel_tick, wrapping HTOT-1 -> 0.
REQ-018 SHALL advance pixel_y only on a pixel_tick where pixel_x = HTOT-1, wrapping VTOT-1 -> 0.
REQ-019 SHALL drive line_end = pixel_tick AND pixel_x = HTOT-1 (combinational, one clk wide).
REQ-020 SHALL drive frame_start = pixel_tick AND pixel_x = HTOT-1 AND pixel_y = VTOT-1; counters read (0,0) on the following clk.
REQ-021 SHALL register h_sync from next-state counters so h_sync is active exactly while pixel_x is in [HD+HFP, HD+HFP+HSW-1]; zero added latency relative to pixel_x.
REQ-022 SHALL register v_sync likewise, active exactly while pixel_y is in [VD+VFP, VD+VFP+VSW-1], for all pixel_x of those lines.
REQ-023 SHALL register video_on = (next pixel_x < HD) AND (next pixel_y < VD), so it is coincident with pixel_x/pixel_y.
REQ-024 SHALL use modular unsigned CW-bit arithmetic; compare-to-end for wrap (no reliance on natural overflow).
REQ-025 SHALL make h_sync/v_sync/video_on glitch-free (direct flop outputs).

Reset
REQ-026 SHALL, while reset=0, asynchronously force divider=0, pixel_x=0, pixel_y=0, h_sync=~HS_POL, v_sync=~VS_POL, video_on=0; pixel_tick, line_end, frame_start read 0.
REQ-027 SHALL, on first clk edge after reset release, set video_on=1 (counters at (0,0)); first pixel_tick occurs CLK_DIV clk edges after release with en=1.
REQ-028 SHALL treat reset assertion mid-frame identically to power-up; no partial line/frame state survives.

Verification
REQ-029 Reset: hold reset=0 with en toggling -> pixel_x=0, pixel_y=0, h_sync=1, v_sync=1, video_on=0, all strobes 0.
REQ-030 Defaults, en=1: pixel_tick period 2 clk; h_sync low exactly for pixel_x 656..751 (96 ticks); line_end every 800 ticks; video_on low from pixel_x 640.
REQ-031 Defaults: v_sync low for pixel_y 490..491 only; frame_start once per 420000 ticks (840000 clk); counters (799,524) -> (0,0) after it.
REQ-032 Enable: drop en at pixel_x=300 for 7 clk -> pixel_x stays 300, no strobes; restore -> next tick gives 301, line still totals 800 ticks.
REQ-033 Overrides HD=4,HFP=1,HSW=2,HBP=1,VD=3,VFP=1,VSW=1,VBP=1,HS_POL=1,VS_POL=1,CLK_DIV=1 -> pixel_tick every clk; h_sync high at pixel_x 5,6; v_sync high at pixel_y 4; HTOT=8, VTOT=6.
REQ-034 Mid-frame reset at pixel_y=200 -> immediate return to REQ-026 values; after release, frame restarts from (0,0) with first tick after 2 clk.
